// File: rtl/systolic_matmul_engine_if.sv
// Job, operand and result bundle for systolic_matmul_engine; the engine side is slave.
interface systolic_matmul_engine_if #(
  parameter int DIM     = 8,
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int KMAX    = 16
);
  localparam int KW = $clog2(KMAX + 1);
  localparam int IW = (DIM > 1) ? $clog2(DIM) : 1;

  logic                            start;
  logic [KW-1:0]                   k_len;
  logic                            clear_acc;
  logic                            a_valid;
  logic                            a_ready;
  logic [DIM-1:0][BITS_AB-1:0]     a_col;
  logic [DIM-1:0][BITS_AB-1:0]     b_row;
  logic                            busy;
  logic                            done;
  logic                            c_valid;
  logic                            c_ready;
  logic [IW-1:0]                   c_row_idx;
  logic [DIM-1:0][BITS_C-1:0]      c_row;
  logic                            ovf;

  modport slave (
    input  start, k_len, clear_acc, a_valid, a_col, b_row, c_ready,
    output a_ready, busy, done, c_valid, c_row_idx, c_row, ovf
  );

  modport master (
    output start, k_len, clear_acc, a_valid, a_col, b_row, c_ready,
    input  a_ready, busy, done, c_valid, c_row_idx, c_row, ovf
  );
endinterface

// File: rtl/systolic_matmul_engine.sv
// Output-stationary DIMxDIM systolic matmul; first result row K+2*DIM cycles after start.
// Operand stream stalls (a_valid=0) inject bubbles; results hold while c_ready is low.
module systolic_matmul_engine #(
  parameter int DIM     = 8,
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int KMAX    = 16,
  parameter int SAT     = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  systolic_matmul_engine_if.slave  io
);
  localparam int KW = $clog2(KMAX + 1);
  localparam int IW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int FW = $clog2(2 * DIM);
  localparam int PW = 2 * BITS_AB;
  localparam int SW = ((BITS_C > PW) ? BITS_C : PW) + 1;

  localparam logic signed [SW-1:0] CMAX = {{(SW-BITS_C+1){1'b0}}, {(BITS_C-1){1'b1}}};
  localparam logic signed [SW-1:0] CMIN = ~CMAX;
  localparam logic [KW-1:0] KMAX_W     = KW'(KMAX);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(2 * DIM - 2);
  localparam logic [IW-1:0] ROW_LAST   = IW'(DIM - 1);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

  state_t        state;
  logic [KW-1:0] k_lat;
  logic [KW-1:0] beat_cnt;
  logic [FW-1:0] flush_cnt;
  logic [IW-1:0] row_idx;
  logic          busy_q;
  logic          a_ready_q;
  logic          c_valid_q;
  logic          done_q;
  logic          ovf_q;

  logic [KW-1:0] k_eff;
  logic          take_job;
  logic          clr;
  logic          adv;
  logic          beat;

  assign k_eff    = (io.k_len > KMAX_W) ? KMAX_W : io.k_len;
  assign take_job = (state == IDLE) && io.start;
  assign clr      = take_job && io.clear_acc;
  assign adv      = (state == LOAD) || (state == FLUSH);
  assign beat     = a_ready_q && io.a_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k_lat     <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      row_idx   <= '0;
      busy_q    <= 1'b0;
      a_ready_q <= 1'b0;
      c_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (io.start) begin
            k_lat     <= k_eff;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            busy_q    <= 1'b1;
            if (k_eff == '0) begin
              state <= FLUSH;
            end else begin
              state     <= LOAD;
              a_ready_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (beat) begin
            if (beat_cnt == k_lat - KW'(1)) begin
              state     <= FLUSH;
              a_ready_q <= 1'b0;
            end else begin
              beat_cnt <= beat_cnt + KW'(1);
            end
          end
        end
        // 2*DIM-1 zero cycles carry the last beat through the skew and across the array
        FLUSH: begin
          if (flush_cnt == FLUSH_LAST) begin
            state     <= DRAIN;
            c_valid_q <= 1'b1;
            row_idx   <= '0;
          end else begin
            flush_cnt <= flush_cnt + FW'(1);
          end
        end
        DRAIN: begin
          if (io.c_ready) begin
            if (row_idx == ROW_LAST) begin
              state     <= IDLE;
              c_valid_q <= 1'b0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              row_idx   <= '0;
            end else begin
              row_idx <= row_idx + IW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic signed [BITS_AB-1:0] a_in   [DIM];
  logic signed [BITS_AB-1:0] b_in   [DIM];
  logic signed [BITS_AB-1:0] a_edge [DIM];
  logic signed [BITS_AB-1:0] b_edge [DIM];

  always_comb begin
    for (int i = 0; i < DIM; i++) begin
      a_in[i] = beat ? $signed(io.a_col[i]) : '0;
      b_in[i] = beat ? $signed(io.b_row[i]) : '0;
    end
  end

  // Lane i is delayed i cycles so operand pairs meet at PE(i,j) on the same edge
  for (genvar gi = 0; gi < DIM; gi++) begin : g_skew
    if (gi == 0) begin : g_direct
      assign a_edge[gi] = a_in[gi];
      assign b_edge[gi] = b_in[gi];
    end else begin : g_delay
      logic signed [BITS_AB-1:0] a_sr [gi];
      logic signed [BITS_AB-1:0] b_sr [gi];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < gi; s++) begin
            a_sr[s] <= '0;
            b_sr[s] <= '0;
          end
        end else if (adv) begin
          a_sr[0] <= a_in[gi];
          b_sr[0] <= b_in[gi];
          for (int s = 1; s < gi; s++) begin
            a_sr[s] <= a_sr[s-1];
            b_sr[s] <= b_sr[s-1];
          end
        end
      end
      assign a_edge[gi] = a_sr[gi-1];
      assign b_edge[gi] = b_sr[gi-1];
    end
  end

  logic signed [BITS_AB-1:0] a_out [DIM][DIM-1];
  logic signed [BITS_AB-1:0] b_out [DIM-1][DIM];
  logic signed [BITS_C-1:0]  acc   [DIM][DIM];
  logic [DIM*DIM-1:0]        hit;

  for (genvar gi = 0; gi < DIM; gi++) begin : g_r
    for (genvar gj = 0; gj < DIM; gj++) begin : g_c
      logic signed [BITS_AB-1:0] a_l;
      logic signed [BITS_AB-1:0] b_t;
      logic signed [PW-1:0]      prod;
      logic signed [SW-1:0]      sum;
      logic signed [BITS_C-1:0]  acc_q;
      logic signed [BITS_C-1:0]  acc_nxt;
      logic                      above;
      logic                      below;

      if (gj == 0) begin : g_a_edge
        assign a_l = a_edge[gi];
      end else begin : g_a_pass
        assign a_l = a_out[gi][gj-1];
      end
      if (gi == 0) begin : g_b_edge
        assign b_t = b_edge[gj];
      end else begin : g_b_pass
        assign b_t = b_out[gi-1][gj];
      end

      assign prod  = $signed({{BITS_AB{a_l[BITS_AB-1]}}, a_l}) *
                     $signed({{BITS_AB{b_t[BITS_AB-1]}}, b_t});
      assign sum   = $signed({{(SW-BITS_C){acc_q[BITS_C-1]}}, acc_q}) +
                     $signed({{(SW-PW){prod[PW-1]}}, prod});
      assign above = sum > CMAX;
      assign below = sum < CMIN;

      always_comb begin
        acc_nxt = sum[BITS_C-1:0];
        if (SAT != 0) begin
          if (above)      acc_nxt = CMAX[BITS_C-1:0];
          else if (below) acc_nxt = CMIN[BITS_C-1:0];
        end
      end

      always_ff @(posedge clk) begin
        if (rst)      acc_q <= '0;
        else if (clr) acc_q <= '0;
        else if (adv) acc_q <= acc_nxt;
      end

      if (gj < DIM - 1) begin : g_a_reg
        logic signed [BITS_AB-1:0] a_q;
        always_ff @(posedge clk) begin
          if (rst)      a_q <= '0;
          else if (adv) a_q <= a_l;
        end
        assign a_out[gi][gj] = a_q;
      end
      if (gi < DIM - 1) begin : g_b_reg
        logic signed [BITS_AB-1:0] b_q;
        always_ff @(posedge clk) begin
          if (rst)      b_q <= '0;
          else if (adv) b_q <= b_t;
        end
        assign b_out[gi][gj] = b_q;
      end

      assign acc[gi][gj]     = acc_q;
      assign hit[gi*DIM+gj]  = adv && (above || below);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       ovf_q <= 1'b0;
    else if (clr)  ovf_q <= 1'b0;
    else if (|hit) ovf_q <= 1'b1;
  end

  always_comb begin
    io.c_row = '0;
    if (c_valid_q) begin
      for (int j = 0; j < DIM; j++) io.c_row[j] = acc[row_idx][j];
    end
  end

  assign io.a_ready   = a_ready_q;
  assign io.busy      = busy_q;
  assign io.done      = done_q;
  assign io.c_valid   = c_valid_q;
  assign io.c_row_idx = row_idx;
  assign io.ovf       = ovf_q;
endmodule
